// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program loader: FSM states and file-table entry layout.
// Each file-table entry is two consecutive words: HD base address, then size in words.
package carregador_programa_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        LE_BASE,
        LE_TAM,
        COPIA,
        FIM,
        FALHA
    } estado_t;

    localparam logic [31:0] OFS_BASE = 32'd0;
    localparam logic [31:0] OFS_TAM  = 32'd1;

    // Word address of one field of entry `id` in the file table.
    function automatic logic [31:0] endereco_entrada(input logic [31:0] id, input logic [31:0] ofs);
        return (id << 1) + ofs;
    endfunction

endpackage

// File: rtl/carregador_programa_contador.sv
// Word counter for the copy loop: cleared before a copy, stepped once per written word.
module contador_palavras (
    input  logic        clock,
    input  logic        reset,
    input  logic        limpar,
    input  logic        incrementar,
    output logic [31:0] valor
);

    logic [31:0] valor_q;
    logic [31:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (limpar) begin
            valor_d = '0;
        end else if (incrementar) begin
            valor_d = valor_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/carregador_programa.sv
// Program loader: looks up a file in the file table, then copies its words
// from secondary storage (HD) into instruction memory starting at DEST_BASE.
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int unsigned TAB_ENTRADAS = 100,
    parameter int unsigned MAX_PALAVRAS = 256,
    parameter logic [31:0] DEST_BASE    = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [31:0] idArquivo,
    output logic [31:0] tabEndereco,
    input  logic [31:0] tabDados,
    output logic [31:0] hdEndereco,
    input  logic [31:0] hdDados,
    output logic [31:0] memEndereco,
    output logic [31:0] memDados,
    output logic        memEscrita,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro
);

    localparam logic [33:0] LIMITE_TAB = 34'(2 * TAB_ENTRADAS);
    localparam logic [31:0] MAX_TAM    = 32'(MAX_PALAVRAS);

    estado_t     estado_q, estado_d;
    logic [31:0] id_q, id_d;
    logic [31:0] base_q, base_d;
    logic [31:0] tamanho_q, tamanho_d;
    logic [31:0] i_q;
    logic        cont_limpar;
    logic        cont_incrementar;

    contador_palavras u_contador (
        .clock       (clock),
        .reset       (reset),
        .limpar      (cont_limpar),
        .incrementar (cont_incrementar),
        .valor       (i_q)
    );

    always_comb begin
        estado_d         = estado_q;
        id_d             = id_q;
        base_d           = base_q;
        tamanho_d        = tamanho_q;
        cont_limpar      = 1'b0;
        cont_incrementar = 1'b0;
        tabEndereco      = '0;
        hdEndereco       = '0;
        memEndereco      = '0;
        memDados         = '0;
        memEscrita       = 1'b0;
        pronto           = 1'b0;
        erro             = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    id_d = idArquivo;
                    // 34-bit compare so huge ids cannot wrap back into range.
                    if ({1'b0, idArquivo, 1'b1} >= LIMITE_TAB) begin
                        estado_d = FALHA;
                    end else begin
                        estado_d = LE_BASE;
                    end
                end
            end
            LE_BASE: begin
                tabEndereco = endereco_entrada(id_q, OFS_BASE);
                base_d      = tabDados;
                estado_d    = LE_TAM;
            end
            LE_TAM: begin
                tabEndereco = endereco_entrada(id_q, OFS_TAM);
                tamanho_d   = tabDados;
                cont_limpar = 1'b1;
                if (tabDados == '0) begin
                    estado_d = FIM;
                end else if (tabDados > MAX_TAM) begin
                    estado_d = FALHA;
                end else begin
                    estado_d = COPIA;
                end
            end
            COPIA: begin
                hdEndereco       = base_q + i_q;
                memEndereco      = DEST_BASE + i_q;
                memDados         = hdDados;
                memEscrita       = 1'b1;
                cont_incrementar = 1'b1;
                if (i_q == tamanho_q - 32'd1) begin
                    estado_d = FIM;
                end
            end
            FIM: begin
                pronto   = 1'b1;
                estado_d = OCIOSO;
            end
            FALHA: begin
                erro     = 1'b1;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign ocupado = (estado_q != OCIOSO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            id_q      <= '0;
            base_q    <= '0;
            tamanho_q <= '0;
        end else begin
            estado_q  <= estado_d;
            id_q      <= id_d;
            base_q    <= base_d;
            tamanho_q <= tamanho_d;
        end
    end

endmodule
